// File: rtl/ring_pkg.sv
// Shared constants for the ring link: packet type codes, transmit select codes,
// header width, transmitter states and the payload nibble checksum.
package ring_pkg;

    localparam logic [2:0] TYPE_ACK    = 3'b000;
    localparam logic [2:0] TYPE_DATA_3 = 3'b001;
    localparam logic [2:0] TYPE_DATA_C = 3'b010;
    localparam logic [2:0] TYPE_NACK   = 3'b011;
    localparam logic [2:0] TYPE_TOKEN  = 3'b111;

    localparam logic [2:0] SEL_ACK     = 3'd0;
    localparam logic [2:0] SEL_NACK    = 3'd1;
    localparam logic [2:0] SEL_FORWARD = 3'd2;
    localparam logic [2:0] SEL_TOKEN   = 3'd3;
    localparam logic [2:0] SEL_NEW     = 3'd4;

    localparam int HDR_W      = 11;
    localparam int MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } tx_state_t;

    // Zero nibbles do not change the result, so narrower payloads are zero-extended.
    function automatic logic [3:0] nibble_xor(input logic [MAX_DATA_W-1:0] d);
        logic [3:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_DATA_W / 4; i++) begin
            acc ^= d[i*4 +: 4];
        end
        return acc;
    endfunction

endpackage

// File: rtl/ring_tx_frame_builder.sv
// Combinational frame assembly: picks header fields and body by select, emits the
// frame left-aligned (start bit at the MSB) together with its length in bits.
module ring_tx_frame_builder
    import ring_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int FRAME_W = HDR_W + 3 + 3 * DATA_W,
    parameter int LEN_W   = $clog2(FRAME_W + 1)
) (
    input  logic [2:0]         sel,
    input  logic [3:0]         r_addr,
    input  logic [2:0]         node_type,
    input  logic [3:0]         node_dest,
    input  logic [DATA_W-1:0]  node_payload,
    input  logic [2:0]         rx_type,
    input  logic [3:0]         rx_dest,
    input  logic [3:0]         rx_src,
    input  logic [DATA_W-1:0]  rx_payload,
    output logic [FRAME_W-1:0] frame,
    output logic [LEN_W-1:0]   frame_len,
    output logic               sel_ok,
    output logic               type_err
);

    logic [2:0]          typ;
    logic [3:0]          dest;
    logic [3:0]          src;
    logic [DATA_W-1:0]   pay;
    logic [3*DATA_W-1:0] body_vec;
    logic [LEN_W-1:0]    body_len;
    logic [HDR_W-1:0]    hdr;
    logic                parity;
    logic [FRAME_W-1:0]  base;
    logic [FRAME_W-1:0]  tail;

    always_comb begin
        typ      = TYPE_ACK;
        dest     = '0;
        src      = r_addr;
        pay      = '0;
        sel_ok   = 1'b1;
        type_err = 1'b0;
        case (sel)
            SEL_ACK: begin
                typ  = TYPE_ACK;
                dest = rx_src;
            end
            SEL_NACK: begin
                typ  = TYPE_NACK;
                dest = rx_src;
            end
            SEL_FORWARD: begin
                typ  = rx_type;
                dest = rx_dest;
                src  = rx_src;
                pay  = rx_payload;
            end
            SEL_TOKEN: begin
                typ  = TYPE_TOKEN;
                dest = r_addr;
            end
            SEL_NEW: begin
                typ      = node_type;
                dest     = node_dest;
                pay      = node_payload;
                type_err = (node_type != TYPE_DATA_C) && (node_type != TYPE_DATA_3);
            end
            default: sel_ok = 1'b0;
        endcase

        // Non-data types fall through with an empty body.
        body_vec = '0;
        body_len = '0;
        if (typ == TYPE_DATA_C) begin
            body_vec = {pay, nibble_xor(MAX_DATA_W'(pay)), {(2*DATA_W-4){1'b0}}};
            body_len = LEN_W'(DATA_W + 4);
        end else if (typ == TYPE_DATA_3) begin
            body_vec = {pay, pay, pay};
            body_len = LEN_W'(3 * DATA_W);
        end

        hdr    = {typ, dest, src};
        parity = ^{hdr, body_vec};
        base   = {1'b0, hdr, body_vec, 2'b00};
        // Parity and stop sit right after the header, then slide past the body.
        tail   = {{(1+HDR_W){1'b0}}, parity, 1'b1, {(3*DATA_W){1'b0}}};
        frame     = base | (tail >> body_len);
        frame_len = LEN_W'(HDR_W + 3) + body_len;
    end

endmodule

// File: rtl/ring_tx.sv
// Ring-link transmitter: latches one request in IDLE, shifts the frame out MSB first,
// then holds the line idle for GAP_CYCLES. Optional TX_BAUD_DIV_EN stretches every bit.
module ring_tx
    import ring_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2,
    parameter int BAUD_DIV   = 4
) (
    input  logic              Clk_R,
    input  logic              Rst,
    input  logic              rc_has_data,
    input  logic [2:0]        tx_data_select,
    input  logic [3:0]        r_addr,
    input  logic [2:0]        node_type,
    input  logic [3:0]        node_dest,
    input  logic [DATA_W-1:0] node_payload,
    input  logic [2:0]        rx_type,
    input  logic [3:0]        rx_dest,
    input  logic [3:0]        rx_src,
    input  logic [DATA_W-1:0] rx_payload,
    output logic              tx_ready,
    output logic              Tx_Serial,
    output logic              Tx_Frame,
    output logic              tx_err
);

    localparam int FRAME_W = HDR_W + 3 + 3 * DATA_W;
    localparam int LEN_W   = $clog2(FRAME_W + 1);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    if (GAP_CYCLES < 0 || GAP_CYCLES > 15 || DATA_W < 4 || (DATA_W % 4) != 0 ||
        DATA_W > MAX_DATA_W || BAUD_DIV < 1) begin : g_param_check
        $error("ring_tx: illegal parameter combination");
    end

    tx_state_t          state, state_nxt;
    logic [FRAME_W-1:0] shreg;
    logic [LEN_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [3:0]         gap_cnt;
    logic               accept;
    logic               reject;
    logic               tick;
    logic               last_bit;
    logic               gap_done;

    logic [FRAME_W-1:0] frame;
    logic [LEN_W-1:0]   frame_len;
    logic               sel_ok;
    logic               type_err;

    ring_tx_frame_builder #(
        .DATA_W  (DATA_W),
        .FRAME_W (FRAME_W),
        .LEN_W   (LEN_W)
    ) u_builder (
        .sel          (tx_data_select),
        .r_addr       (r_addr),
        .node_type    (node_type),
        .node_dest    (node_dest),
        .node_payload (node_payload),
        .rx_type      (rx_type),
        .rx_dest      (rx_dest),
        .rx_src       (rx_src),
        .rx_payload   (rx_payload),
        .frame        (frame),
        .frame_len    (frame_len),
        .sel_ok       (sel_ok),
        .type_err     (type_err)
    );

`ifdef TX_BAUD_DIV_EN
    localparam int BD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    logic [BD_W-1:0] baud_cnt;

    assign tick = (baud_cnt == BD_W'(BAUD_DIV - 1));

    // Restarting on accept keeps the start bit at the first edge after the request.
    always_ff @(posedge Clk_R) begin
        if (Rst || accept || tick || state == ST_IDLE) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign last_bit = (bit_cnt == len_q);
    assign gap_done = (gap_cnt == GAP_LAST);

    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        tx_ready  = 1'b0;
        Tx_Frame  = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (rc_has_data) begin
                    if (sel_ok) begin
                        accept    = 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                Tx_Frame = 1'b1;
                if (tick && last_bit) begin
                    state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick && gap_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            len_q     <= '0;
            gap_cnt   <= '0;
            Tx_Serial <= 1'b1;
            tx_err    <= 1'b0;
        end else begin
            tx_err <= reject | (accept & type_err);
            if (accept) begin
                Tx_Serial <= frame[FRAME_W-1];
                shreg     <= frame << 1;
                bit_cnt   <= LEN_W'(1);
                len_q     <= frame_len;
            end else if (state == ST_SEND && tick) begin
                if (last_bit) begin
                    Tx_Serial <= 1'b1;
                    gap_cnt   <= '0;
                end else begin
                    Tx_Serial <= shreg[FRAME_W-1];
                    shreg     <= shreg << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                end
            end else if (state == ST_GAP && tick) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ring_tx.sv
// Scoreboard bench for ring_tx: a bit-level model queues each expected frame at
// request time and a negedge monitor pops and compares the serial stream.
module tb_ring_tx;
    import ring_pkg::*;

    localparam int DATA_W = 8;
    localparam int GAP    = 2;
`ifdef TX_BAUD_DIV_EN
    localparam int BPC = 4;
`else
    localparam int BPC = 1;
`endif

    logic              Clk_R;
    logic              Rst;
    logic              rc_has_data;
    logic [2:0]        tx_data_select;
    logic [3:0]        r_addr;
    logic [2:0]        node_type;
    logic [3:0]        node_dest;
    logic [DATA_W-1:0] node_payload;
    logic [2:0]        rx_type;
    logic [3:0]        rx_dest;
    logic [3:0]        rx_src;
    logic [DATA_W-1:0] rx_payload;
    logic              tx_ready;
    logic              Tx_Serial;
    logic              Tx_Frame;
    logic              tx_err;

    ring_tx #(.DATA_W(DATA_W), .GAP_CYCLES(GAP), .BAUD_DIV(4)) dut (
        .Clk_R          (Clk_R),
        .Rst            (Rst),
        .rc_has_data    (rc_has_data),
        .tx_data_select (tx_data_select),
        .r_addr         (r_addr),
        .node_type      (node_type),
        .node_dest      (node_dest),
        .node_payload   (node_payload),
        .rx_type        (rx_type),
        .rx_dest        (rx_dest),
        .rx_src         (rx_src),
        .rx_payload     (rx_payload),
        .tx_ready       (tx_ready),
        .Tx_Serial      (Tx_Serial),
        .Tx_Frame       (Tx_Frame),
        .tx_err         (tx_err)
    );

    initial Clk_R = 1'b0;
    always #5 Clk_R = ~Clk_R;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    bit exp_q[$];
    int len_q[$];
    int mon_cnt = 0;
    logic prev_frame = 1'b0;

    always @(negedge Clk_R) begin
        if (Rst) begin
            mon_cnt    = 0;
            prev_frame = 1'b0;
        end else begin
            if (Tx_Frame) begin
                if (mon_cnt % BPC == 0) begin
                    chk("bit_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("bit", Tx_Serial, exp_q.pop_front());
                end
                mon_cnt++;
            end else if (prev_frame) begin
                chk("frame_pending", len_q.size() > 0, 1);
                if (len_q.size() > 0) chk("frame_len", mon_cnt, len_q.pop_front() * BPC);
                mon_cnt = 0;
            end
            prev_frame = Tx_Frame;
        end
    end

    task automatic push_bits(input logic [63:0] v, input int w, inout logic par);
        for (int i = w - 1; i >= 0; i--) begin
            exp_q.push_back(v[i]);
            par ^= v[i];
        end
    endtask

    task automatic model(input logic [2:0] sel, output logic exp_err);
        logic [2:0] t;
        logic [3:0] d, s, ck;
        logic [DATA_W-1:0] p;
        logic par;
        int n;
        exp_err = 1'b0;
        s = r_addr;
        p = '0;
        t = 3'b000;
        d = 4'h0;
        case (sel)
            3'd0: begin t = 3'b000; d = rx_src; end
            3'd1: begin t = 3'b011; d = rx_src; end
            3'd2: begin t = rx_type; d = rx_dest; s = rx_src; p = rx_payload; end
            3'd3: begin t = 3'b111; d = r_addr; end
            3'd4: begin
                t = node_type; d = node_dest; p = node_payload;
                if (node_type != 3'b010 && node_type != 3'b001) exp_err = 1'b1;
            end
            default: begin exp_err = 1'b1; return; end
        endcase
        par = 1'b0;
        n = 14;
        exp_q.push_back(1'b0);
        push_bits(64'(t), 3, par);
        push_bits(64'(d), 4, par);
        push_bits(64'(s), 4, par);
        if (t == 3'b010) begin
            push_bits(64'(p), DATA_W, par);
            ck = 4'h0;
            for (int i = 0; i < DATA_W / 4; i++) ck ^= p[i*4 +: 4];
            push_bits(64'(ck), 4, par);
            n += DATA_W + 4;
        end else if (t == 3'b001) begin
            for (int r = 0; r < 3; r++) push_bits(64'(p), DATA_W, par);
            n += 3 * DATA_W;
        end
        exp_q.push_back(par);
        exp_q.push_back(1'b1);
        len_q.push_back(n);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge Clk_R);
        while (!tx_ready && k < 400) begin
            @(negedge Clk_R);
            k++;
        end
        chk("wait_ready", tx_ready, 1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge Clk_R);
        while (!(tx_ready && exp_q.size() == 0) && k < 400) begin
            @(negedge Clk_R);
            k++;
        end
        chk("wait_done", tx_ready && exp_q.size() == 0, 1);
    endtask

    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic send(input logic [2:0] sel, input bit use_model);
        logic e;
        wait_ready();
        @(negedge Clk_R);
        tx_data_select = sel;
        rc_has_data = 1'b1;
        if (use_model) model(sel, e);
        else e = 1'b0;
        @(posedge Clk_R);
        #1 rc_has_data = 1'b0;
        @(negedge Clk_R);
        chk("tx_err_at_accept", tx_err, e);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] tok;
        int k;
        Rst = 1'b1;
        rc_has_data = 1'b0;
        tx_data_select = 3'd0;
        r_addr = 4'd3;
        node_type = 3'b010;
        node_dest = 4'd0;
        node_payload = '0;
        rx_type = 3'b000;
        rx_dest = 4'd0;
        rx_src = 4'd0;
        rx_payload = '0;
        repeat (3) @(posedge Clk_R);
        @(negedge Clk_R);
        chk("rst_ready", tx_ready, 1);
        chk("rst_serial", Tx_Serial, 1);
        chk("rst_frame", Tx_Frame, 0);
        chk("rst_err", tx_err, 0);
        Rst = 1'b0;

        // TOKEN from r_addr=3 against the literal bit sequence
        tok = 14'b01110011001111;
        for (int i = 13; i >= 0; i--) exp_q.push_back(tok[i]);
        len_q.push_back(14);
        send(SEL_TOKEN, 0);
        chk("token_busy", tx_ready, 0);
        k = 1;
        while (!tx_ready && k < 200) begin
            @(negedge Clk_R);
            k++;
        end
        chk("token_ready_lat", k, 1 + (14 + GAP) * BPC);
        wait_done();

        node_type = 3'b010; node_dest = 4'd5; node_payload = 8'hA5;
        send(SEL_NEW, 1);
        wait_done();

        node_type = 3'b001; node_payload = 8'h3C;
        send(SEL_NEW, 1);
        wait_done();

        rx_type = 3'b000; rx_dest = 4'd2; rx_src = 4'd9;
        send(SEL_FORWARD, 1);
        wait_done();
        send(SEL_ACK, 1);
        wait_done();
        send(SEL_NACK, 1);
        wait_done();

        rx_type = 3'b010; rx_dest = 4'd7; rx_src = 4'd1; rx_payload = 8'h5A;
        send(SEL_FORWARD, 1);
        wait_done();
        rx_type = 3'b101;
        send(SEL_FORWARD, 1);
        wait_done();

        for (int i = 0; i < 4; i++) begin
            rx_type = (i % 2 == 0) ? 3'b001 : 3'b010;
            rx_dest = 4'($urandom_range(0, 15));
            rx_src = 4'($urandom_range(0, 15));
            rx_payload = 8'($urandom_range(0, 255));
            r_addr = 4'($urandom_range(0, 15));
            send(SEL_FORWARD, 1);
            wait_done();
        end
        r_addr = 4'd3;

        // Rejected selects
        for (int s = 5; s <= 7; s++) begin
            send(3'(s), 1);
            chk("bad_sel_ready", tx_ready, 1);
            chk("bad_sel_serial", Tx_Serial, 1);
            chk("bad_sel_frame", Tx_Frame, 0);
            @(negedge Clk_R);
            chk("bad_sel_err_clear", tx_err, 0);
        end

        node_type = 3'b100; node_dest = 4'd6;
        send(SEL_NEW, 1);
        @(negedge Clk_R);
        chk("new_bad_type_err_clear", tx_err, 0);
        wait_done();

        // Requests during SEND must be dropped
        node_type = 3'b001; node_payload = 8'hC3;
        send(SEL_NEW, 1);
        tx_data_select = SEL_TOKEN;
        rc_has_data = 1'b1;
        repeat (5) @(negedge Clk_R);
        chk("busy_ready", tx_ready, 0);
        rc_has_data = 1'b0;
        wait_done();
        repeat (6) @(negedge Clk_R);
        chk("no_extra_frame", Tx_Frame, 0);
        chk("no_extra_queue", len_q.size(), 0);

        // Reset in the middle of a DATA_C frame
        node_type = 3'b010; node_dest = 4'd5; node_payload = 8'hA5;
        send(SEL_NEW, 1);
        k = 0;
        while (mon_cnt < 7 && k < 100) begin
            @(negedge Clk_R);
            k++;
        end
        chk("reached_bit7", mon_cnt >= 7, 1);
        Rst = 1'b1;
        @(posedge Clk_R);
        @(negedge Clk_R);
        chk("midrst_serial", Tx_Serial, 1);
        chk("midrst_frame", Tx_Frame, 0);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_err", tx_err, 0);
        exp_q.delete();
        len_q.delete();
        Rst = 1'b0;

        r_addr = 4'd3;
        send(SEL_TOKEN, 1);
        wait_done();

        repeat (4) @(negedge Clk_R);
        chk("queues_drained", exp_q.size() + len_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
